load_store_unit: RTL and testbench

- Sits directly upstream of the byte-addressed, word-wide R/W data memory (async read, sync write, no byte enables).
- Accepts load/store requests of byte, halfword or word size from the core and drives the memory port.
- Sub-word loads: lane extraction plus sign/zero extension.
- Sub-word stores: read-modify-write sequence, because the memory writes whole words only.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide memory; sub-word stores use read-modify-write. Optional trap: LSU_MISALIGN_TRAP_EN.
// Latency: load/word store/error 1 cycle, sub-word store 2 cycles, then a 1-cycle o_rvalid; o_ready only in IDLE (core holds request).
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_error,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("load_store_unit supports DATA_WIDTH = 32 only");
  end

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RMW_RD,
`ifdef LSU_MISALIGN_TRAP_EN
    S_RMW_WR,
    S_ERR
`else
    S_RMW_WR
`endif
  } state_t;

  // Latched request; size and lane are stored already normalised (no 2'b11 size, lane aligned to size).
  typedef struct packed {
    logic [1:0]            lane;
    logic [1:0]            size;
    logic                  is_unsigned;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t state;
  req_t   req;

  logic [1:0]            eff_size;
  logic [1:0]            eff_lane;
  logic                  illegal;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_val;

  assign o_ready = (state == S_IDLE);

  always_comb begin
    eff_size = (i_size == 2'b11) ? SZ_WORD : i_size;
    case (eff_size)
      SZ_BYTE: eff_lane = i_addr[1:0];
      SZ_HALF: eff_lane = {i_addr[1], 1'b0};
      default: eff_lane = 2'b00;
    endcase
    illegal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    illegal = (i_size == 2'b11) ||
              ((i_size == SZ_HALF) && i_addr[0]) ||
              ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
`endif
  end

  // Lane merge for RMW and lane extraction for loads share one shift amount.
  always_comb begin
    shamt = {req.lane, 3'b000};
    case (req.size)
      SZ_BYTE: lane_mask = 32'h0000_00FF << shamt;
      SZ_HALF: lane_mask = 32'h0000_FFFF << shamt;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    merged  = (i_mem_rdata & ~lane_mask) | ((req.wdata << shamt) & lane_mask);
    shifted = i_mem_rdata >> shamt;
    case (req.size)
      SZ_BYTE: load_val = req.is_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = req.is_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = i_mem_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic error_q;
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      req         <= '0;
      o_rvalid    <= 1'b0;
      o_rdata     <= '0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      error_q     <= 1'b0;
`endif
    end else begin
      o_rvalid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      error_q  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          o_mem_we <= 1'b0;
          if (i_req) begin
            req.lane        <= eff_lane;
            req.size        <= eff_size;
            req.is_unsigned <= i_unsigned;
            req.wdata       <= i_wdata;
            if (illegal) begin
`ifdef LSU_MISALIGN_TRAP_EN
              state <= S_ERR;
`endif
            end else begin
              o_mem_addr <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
              if (!i_we) begin
                state <= S_LOAD;
              end else if (eff_size == SZ_WORD) begin
                state       <= S_WRITE;
                o_mem_we    <= 1'b1;
                o_mem_wdata <= i_wdata;
              end else begin
                state <= S_RMW_RD;
              end
            end
          end
        end
        S_LOAD: begin
          o_rdata  <= load_val;
          o_rvalid <= 1'b1;
          state    <= S_IDLE;
        end
        S_WRITE: begin
          o_mem_we <= 1'b0;
          o_rvalid <= 1'b1;
          state    <= S_IDLE;
        end
        S_RMW_RD: begin
          o_mem_wdata <= merged;
          o_mem_we    <= 1'b1;
          state       <= S_RMW_WR;
        end
        S_RMW_WR: begin
          o_mem_we <= 1'b0;
          o_rvalid <= 1'b1;
          state    <= S_IDLE;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        S_ERR: begin
          o_rvalid <= 1'b1;
          error_q  <= 1'b1;
          state    <= S_IDLE;
        end
`endif
        default: begin
          o_mem_we <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, word-wide memory model, random plus directed requests.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, rvalid, error, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_req(req), .o_ready(ready),
    .i_addr(addr), .i_we(we), .i_size(size), .i_unsigned(uns), .i_wdata(wdata),
    .o_rvalid(rvalid), .o_rdata(rdata), .o_error(error),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // 256-byte memory, aliased across the full address space
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] = mem_wdata;

  logic [7:0] ref_mem [256];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  exp_t        q[$];
  exp_t        m_e;
  logic [31:0] last_rd = '0;
  int          cyc = 0;
  int          we_run = 0;
  int          n_total = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_total++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req_v);
    end
  endtask

  // Monitor: pops one expectation per completion pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (q.size() == 0) begin
          check("unexpected_rvalid", 32'(rvalid), 32'd0);
        end else begin
          m_e = q.pop_front();
          check("rdata", rdata, m_e.rdata);
          check("error", 32'(error), 32'(m_e.err));
          check("latency", 32'(cyc - m_e.acc), 32'(m_e.lat));
        end
      end
      if (mem_we) we_run++;
      else if (we_run != 0) begin
        check("mem_we_pulse_len", 32'(we_run), 32'd1);
        we_run = 0;
      end
    end else begin
      we_run = 0;
    end
  end

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic set_word(input logic [7:0] a, input logic [31:0] v);
    mem[a[7:2]] = v;
    for (int i = 0; i < 4; i++) ref_mem[{a[7:2], 2'b00} + 8'(i)] = 8'(v >> (8 * i));
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] wd);
    exp_t e;
    int nb;
    logic [7:0] base;
    logic [31:0] v;
    logic trap;
    @(negedge clk);
    addr = a; we = w; size = s; uns = u; wdata = wd; req = 1'b1;
    for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
    if (!ready) begin
      check("accept_timeout", 32'(ready), 32'd1);
      req = 1'b0;
      return;
    end
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
`endif
    nb   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    base = a[7:0] & ~8'(nb - 1);
    e.err = trap;
    e.acc = cyc + 1;
    e.lat = 1;
    e.rdata = last_rd;
    if (!trap && !w) begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + 8'(i)]) << (8 * i));
      if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      e.rdata = v;
      last_rd = v;
    end else if (!trap) begin
      for (int i = 0; i < nb; i++) ref_mem[base + 8'(i)] = 8'(wd >> (8 * i));
      e.lat = (nb == 4) ? 1 : 2;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    check("ready_low_busy", 32'(ready), 32'd0);
    if (!trap) check("mem_addr", mem_addr, {a[31:2], 2'b00});
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    check("drain_queue", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] snap [4];
    for (int i = 0; i < 64; i++) set_word(8'(4 * i), $urandom);

    // Reset state
    @(negedge clk);
    check("rst_outputs", {rvalid, error, mem_we, 29'd0} | rdata | mem_addr | mem_wdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte store RMW
    set_word(8'h10, 32'hAABBCCDD);
    issue(32'h12, 1'b1, 2'b00, 1'b0, 32'h0000_0011);
    idle(); drain();
    check("byte_store_word", mem[4], 32'hAA11CCDD);

    // Signed/unsigned loads, back to back
    set_word(8'h20, 32'h80F17F01);
    issue(32'h21, 1'b0, 2'b00, 1'b0, '0);
    issue(32'h22, 1'b0, 2'b00, 1'b0, '0);
    issue(32'h22, 1'b0, 2'b01, 1'b1, '0);
    issue(32'h20, 1'b0, 2'b10, 1'b0, '0);
    idle(); drain();

    // Word store then load accepted in the completion cycle
    issue(32'h30, 1'b1, 2'b10, 1'b0, 32'h12345678);
    issue(32'h30, 1'b0, 2'b10, 1'b0, '0);
    idle(); drain();

    // Half store at odd address
    set_word(8'h40, 32'h01234567);
    issue(32'h41, 1'b1, 2'b01, 1'b0, 32'h0000BEEF);
    idle(); drain();
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_mem", mem[16], 32'h01234567);
`else
    check("misalign_mem", mem[16], 32'h0123BEEF);
`endif

    // Top of address space
    issue(32'hFFFF_FFFC, 1'b0, 2'b10, 1'b0, '0);
    issue(32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 32'h0000_005A);
    idle(); drain();

    // Reset in the RMW write cycle
    for (int i = 0; i < 4; i++) snap[i] = ref_mem[8'h50 + 8'(i)];
    issue(32'h51, 1'b1, 2'b00, 1'b0, 32'h0000_00C3);
    idle();
    @(negedge clk);
    check("rmw_wr_we", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_we_drop", 32'(mem_we), 32'd0);
    check("rst_mid_outputs", {rvalid, error, 30'd0} | rdata | mem_addr | mem_wdata, 32'd0);
    @(negedge clk);
    check("rst_mid_mem", mem[20], {snap[3], snap[2], snap[1], snap[0]});
    for (int i = 0; i < 4; i++) ref_mem[8'h50 + 8'(i)] = snap[i];
    q.delete();
    last_rd = '0;
    rst_n = 1'b1;
    #1 check("rst_release_ready", 32'(ready), 32'd1);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? $urandom : {24'd0, 8'($urandom)};
      issue(ra, 1'($urandom), 2'($urandom), 1'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle(); drain();

    for (int w = 0; w < 64; w++) check("final_mem", mem[w], ref_word(w));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
